ecfs_trigger_sequencer: RTL

Fans one PWM-carrier synchronisation trigger out to up to five downstream consumers (ADC sample start, encoder latch, current-loop ISR kick, etc.), each with its own programmable delay and a common pulse width. It sits in the ssg_emb_pwm subsystem between the PWM carrier sync output and the blocks that previously received a raw copy of that sync. It is the sequencing controller for that fan-out. Per-trigger configuration is shadowed, so software reprogramming never tears a sequence in flight.

---
 rtl/ecfs_trigger_sequencer.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/ecfs_trigger_sequencer.sv
// Purpose : fans one PWM carrier sync edge out to up to five delayed, fixed-width trigger pulses.
// Latency : trig_out_i rises delay_i+1 cycles after the edge is sampled; all outputs are registered.
// Backpressure: none; an edge arriving mid-sequence is dropped and flagged as overrun.
//
// Ports:
//   clk, reset_n            - clock, asynchronous active-low reset
//   trig_in                 - carrier sync (synchronous to clk), rising edge starts a sequence
//   out_en                  - per-output enable mask, shadowed at sequence start
//   delay_0..delay_4        - cycles from trigger to pulse start, shadowed at sequence start
//   pulse_len               - pulse width minus one, shadowed at sequence start
//   clr_overrun             - synchronous clear of overrun status
//   trig_out_0..trig_out_4  - delayed trigger pulses (outputs >= OUTPUT_NUM tied low)
//   busy                    - a sequence is running
//   overrun                 - sticky: an edge was dropped because a sequence was running
//   overrun_cnt             - saturating dropped-edge count, only with ECFS_TRIG_OVERRUN_CNT_EN
//
// Build option: define ECFS_TRIG_OVERRUN_CNT_EN to add the overrun_cnt port and counter.
module ecfs_trigger_sequencer #(
  parameter int OUTPUT_NUM = 5,
  parameter int DELAY_W    = 16,
  parameter int PULSE_W    = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  trig_in,
  input  logic [OUTPUT_NUM-1:0] out_en,
  input  logic [DELAY_W-1:0]    delay_0,
  input  logic [DELAY_W-1:0]    delay_1,
  input  logic [DELAY_W-1:0]    delay_2,
  input  logic [DELAY_W-1:0]    delay_3,
  input  logic [DELAY_W-1:0]    delay_4,
  input  logic [PULSE_W-1:0]    pulse_len,
  input  logic                  clr_overrun,
  output logic                  trig_out_0,
  output logic                  trig_out_1,
  output logic                  trig_out_2,
  output logic                  trig_out_3,
  output logic                  trig_out_4,
  output logic                  busy,
  output logic                  overrun
`ifdef ECFS_TRIG_OVERRUN_CNT_EN
  ,
  output logic [7:0]            overrun_cnt
`endif
);

  localparam int MAX_OUT = 5;

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_q, state_d;
  logic                 trig_d;
  logic                 trig_edge;
  logic                 accept;
  logic                 drop;
  logic                 drop_q;
  logic                 seq_done;

  logic [MAX_OUT-1:0]   en_ext;
  logic [DELAY_W-1:0]   dly    [MAX_OUT];
  logic [MAX_OUT-1:0]   sh_en;
  logic [DELAY_W-1:0]   sh_dly [MAX_OUT];
  logic [PULSE_W-1:0]   sh_pl;
  logic [DELAY_W-1:0]   cnt_q;

  logic [MAX_OUT-1:0]   fired_q;
  logic [MAX_OUT-1:0]   act_q;
  logic [PULSE_W-1:0]   pcnt_q [MAX_OUT];
  logic [MAX_OUT-1:0]   start;
  logic [MAX_OUT-1:0]   last;

  assign trig_edge = trig_in & ~trig_d;

  // Widen the mask to the full five slots; slots beyond OUTPUT_NUM never enable.
  always_comb begin
    en_ext                 = '0;
    en_ext[OUTPUT_NUM-1:0] = out_en;
    dly[0]                 = delay_0;
    dly[1]                 = delay_1;
    dly[2]                 = delay_2;
    dly[3]                 = delay_3;
    dly[4]                 = delay_4;
  end

  // Per-output start and final-pulse-cycle detection, all on shadowed config.
  always_comb begin
    start = '0;
    last  = '0;
    for (int i = 0; i < MAX_OUT; i++) begin
      start[i] = (state_q == RUN) && sh_en[i] && !fired_q[i] && (cnt_q == sh_dly[i]);
      last[i]  = act_q[i] && (pcnt_q[i] == sh_pl);
    end
  end

  // Done in the cycle whose closing edge drops the last pulse, so a sequence
  // can be re-armed at exactly that edge without a dead cycle.
  assign seq_done = (state_q == RUN) && (&((~sh_en | fired_q) & (~act_q | last)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    drop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (trig_edge && (|en_ext)) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (seq_done) begin
          if (trig_edge && (|en_ext)) begin
            accept  = 1'b1;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end else if (trig_edge) begin
          drop = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trig_d  <= 1'b0;
      sh_en   <= '0;
      sh_pl   <= '0;
      cnt_q   <= '0;
      fired_q <= '0;
      act_q   <= '0;
      for (int i = 0; i < MAX_OUT; i++) begin
        sh_dly[i] <= '0;
        pcnt_q[i] <= '0;
      end
    end else begin
      trig_d <= trig_in;
      if (accept) begin
        sh_en   <= en_ext;
        sh_pl   <= pulse_len;
        cnt_q   <= '0;
        fired_q <= '0;
        // Any pulse still high here is in its final cycle, so clearing is safe.
        act_q   <= '0;
        for (int i = 0; i < MAX_OUT; i++) begin
          sh_dly[i] <= dly[i];
          pcnt_q[i] <= '0;
        end
      end else if (state_q == RUN) begin
        if (cnt_q != '1) begin
          cnt_q <= cnt_q + DELAY_W'(1);
        end
        for (int i = 0; i < MAX_OUT; i++) begin
          if (start[i]) begin
            act_q[i]   <= 1'b1;
            fired_q[i] <= 1'b1;
            pcnt_q[i]  <= '0;
          end else if (act_q[i]) begin
            if (last[i]) begin
              act_q[i] <= 1'b0;
            end else begin
              pcnt_q[i] <= pcnt_q[i] + PULSE_W'(1);
            end
          end
        end
      end
    end
  end

  // busy lags entry into RUN by one edge but leaves with the last pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy    <= 1'b0;
      drop_q  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      busy   <= (state_q == RUN) && (state_d == RUN);
      drop_q <= drop;
      if (drop_q) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

`ifdef ECFS_TRIG_OVERRUN_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun_cnt <= 8'd0;
    end else if (clr_overrun) begin
      overrun_cnt <= drop_q ? 8'd1 : 8'd0;
    end else if (drop_q && (overrun_cnt != 8'hff)) begin
      overrun_cnt <= overrun_cnt + 8'd1;
    end
  end
`endif

  assign trig_out_0 = act_q[0];
  assign trig_out_1 = (OUTPUT_NUM > 1) ? act_q[1] : 1'b0;
  assign trig_out_2 = (OUTPUT_NUM > 2) ? act_q[2] : 1'b0;
  assign trig_out_3 = (OUTPUT_NUM > 3) ? act_q[3] : 1'b0;
  assign trig_out_4 = (OUTPUT_NUM > 4) ? act_q[4] : 1'b0;

endmodule
